// File: rtl/traffic_phase_ctrl.sv
// Two-direction traffic-light phase controller: timed G/Y/all-red cycle with demand
// shortening of the opposing green and a blinking-yellow night mode.
module traffic_phase_ctrl #(
    parameter int CNT_W   = 7,
    parameter int Y_TIME  = 5,
    parameter int AR_TIME = 1,
    parameter int SHORT_T = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_1s,
    input  logic             k_night,
    input  logic [CNT_W-1:0] g1_time,
    input  logic [CNT_W-1:0] g2_time,
    input  logic             req1,
    input  logic             req2,
    output logic             R1,
    output logic             Y1,
    output logic             G1,
    output logic             R2,
    output logic             Y2,
    output logic             G2,
    output logic [CNT_W-1:0] cnt,
    output logic [2:0]       state,
    output logic             phase_go
);

    typedef enum logic [2:0] {
        S_NIGHT = 3'd0, S_G1 = 3'd1, S_Y1 = 3'd2, S_AR1 = 3'd3,
        S_G2 = 3'd4, S_Y2 = 3'd5, S_AR2 = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] Y_DUR     = (Y_TIME == 0) ? CNT_W'(1) : CNT_W'(Y_TIME);
    localparam logic [CNT_W-1:0] AR_DUR    = CNT_W'(AR_TIME);
    localparam logic [CNT_W-1:0] SHORT_DUR = CNT_W'(SHORT_T);
    localparam bit               HAS_AR    = (AR_TIME != 0);

    state_t           state_q, state_d, nxt_state;
    logic [CNT_W-1:0] cnt_q, cnt_d, nxt_dur, g1_dur, g2_dur;
    logic             blink_q, blink_d;
    logic             d1_q, d1_d, d2_q, d2_d;
    logic             phase_go_q, phase_go_d;

    assign g1_dur = (g1_time == '0) ? CNT_W'(1) : g1_time;
    assign g2_dur = (g2_time == '0) ? CNT_W'(1) : g2_time;

    // Successor phase and its duration; NIGHT exits like Y2 so service restarts at dir 1.
    always_comb begin
        nxt_state = S_NIGHT;
        nxt_dur   = '0;
        case (state_q)
            S_G1:  begin nxt_state = S_Y1; nxt_dur = Y_DUR; end
            S_Y1:  begin
                nxt_state = HAS_AR ? S_AR1 : S_G2;
                nxt_dur   = HAS_AR ? AR_DUR : g2_dur;
            end
            S_AR1: begin nxt_state = S_G2; nxt_dur = g2_dur; end
            S_G2:  begin nxt_state = S_Y2; nxt_dur = Y_DUR; end
            S_AR2: begin nxt_state = S_G1; nxt_dur = g1_dur; end
            default: begin
                nxt_state = HAS_AR ? S_AR2 : S_G1;
                nxt_dur   = HAS_AR ? AR_DUR : g1_dur;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blink_d = blink_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        if (k_night) begin
            state_d = S_NIGHT;
            cnt_d   = '0;
            if (state_q == S_NIGHT && tick_1s) blink_d = ~blink_q;
        end else if (state_q == S_NIGHT) begin
            if (tick_1s) begin
                state_d = nxt_state;
                cnt_d   = nxt_dur;
                blink_d = 1'b0;
            end
        end else begin
            d1_d = d1_q | req1;
            d2_d = d2_q | req2;
            // Shortening takes priority over the tick; that tick's decrement is dropped.
            if ((state_q == S_G1 && d2_d && cnt_q > SHORT_DUR) ||
                (state_q == S_G2 && d1_d && cnt_q > SHORT_DUR)) begin
                cnt_d = SHORT_DUR;
            end else if (tick_1s) begin
                if (cnt_q > CNT_W'(1)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = nxt_state;
                    cnt_d   = nxt_dur;
                end
            end
        end
        if (state_d == S_G1 && state_q != S_G1) d1_d = 1'b0;
        if (state_d == S_G2 && state_q != S_G2) d2_d = 1'b0;
        phase_go_d = (state_d != state_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_NIGHT;
            cnt_q      <= '0;
            blink_q    <= 1'b0;
            d1_q       <= 1'b0;
            d2_q       <= 1'b0;
            phase_go_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            blink_q    <= blink_d;
            d1_q       <= d1_d;
            d2_q       <= d2_d;
            phase_go_q <= phase_go_d;
        end
    end

    always_comb begin
        R1 = 1'b0; Y1 = 1'b0; G1 = 1'b0;
        R2 = 1'b0; Y2 = 1'b0; G2 = 1'b0;
        case (state_q)
            S_G1:         begin G1 = 1'b1; R2 = 1'b1; end
            S_Y1:         begin Y1 = 1'b1; R2 = 1'b1; end
            S_AR1, S_AR2: begin R1 = 1'b1; R2 = 1'b1; end
            S_G2:         begin R1 = 1'b1; G2 = 1'b1; end
            S_Y2:         begin R1 = 1'b1; Y2 = 1'b1; end
            default:      begin Y1 = blink_q; Y2 = blink_q; end
        endcase
    end

    assign cnt      = cnt_q;
    assign state    = state_q;
    assign phase_go = phase_go_q;

endmodule
